// File: rtl/uart_pkg.sv
// Shared UART constants: character width and receive FIFO sizing defaults.
package uart_pkg;
    localparam int UART_DATA_W             = 8;
    localparam int UART_RX_FIFO_DEPTH_LOG2 = 4;
    localparam int UART_RX_FIFO_AF_LEVEL   = 12;
endpackage

// File: rtl/uart_rx_fifo_if.sv
// Receiver-to-FIFO and FIFO-to-host signal bundle; slave is the FIFO, master drives strobe/pop/clear.
interface uart_rx_fifo_if import uart_pkg::*; #(
    parameter int DATA_WIDTH = UART_DATA_W,
    parameter int DEPTH_LOG2 = UART_RX_FIFO_DEPTH_LOG2
);
    logic                  ena_rxd;
    logic [DATA_WIDTH-1:0] data_i;
    logic                  rd_en;
    logic                  clr_ovf;
    logic [DATA_WIDTH-1:0] data_o;
    logic                  empty;
    logic                  full;
    logic                  almost_full;
    logic [DEPTH_LOG2:0]   level;
    logic                  overflow;

    modport master (
        output ena_rxd, data_i, rd_en, clr_ovf,
        input  data_o, empty, full, almost_full, level, overflow
    );

    modport slave (
        input  ena_rxd, data_i, rd_en, clr_ovf,
        output data_o, empty, full, almost_full, level, overflow
    );
endinterface

// File: rtl/uart_fifo_mem.sv
// Simple dual-port storage: synchronous write, asynchronous read, array not reset.
module uart_fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_W     = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO: stores one byte per ena_rxd rising edge (visible next cycle), FWFT read.
// No receive backpressure: a write to a full FIFO without a same-cycle pop is dropped and flags overflow.
module uart_rx_fifo import uart_pkg::*; #(
    parameter int DATA_WIDTH        = UART_DATA_W,
    parameter int DEPTH_LOG2        = UART_RX_FIFO_DEPTH_LOG2,
    parameter int ALMOST_FULL_LEVEL = UART_RX_FIFO_AF_LEVEL
) (
    input  logic           clk,
    input  logic           rst,
    uart_rx_fifo_if.slave  bus
);
    localparam int PW = DEPTH_LOG2 + 1;
    localparam logic [PW-1:0] AF_LEVEL = PW'(ALMOST_FULL_LEVEL);

    logic                  ena_q;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  overflow_q;
    logic [DATA_WIDTH-1:0] head;
    logic                  wr;
    logic                  pop;
    logic                  wr_ok;
    logic                  drop;
    logic                  empty_w;
    logic                  full_w;
    logic [PW-1:0]         level_w;

    assign empty_w = (wr_ptr == rd_ptr);
    assign full_w  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                     (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    assign level_w = wr_ptr - rd_ptr;

    // ena_q resets high so the receiver's idle-high level after reset is not a write.
    assign wr    = bus.ena_rxd & ~ena_q;
    assign pop   = bus.rd_en & ~empty_w;
    assign wr_ok = wr & (~full_w | pop);
    assign drop  = wr & full_w & ~pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ena_q      <= 1'b1;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow_q <= 1'b0;
        end else begin
            ena_q <= bus.ena_rxd;
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            // A drop in the same cycle as a clear keeps the flag set.
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (bus.clr_ovf) begin
                overflow_q <= 1'b0;
            end
        end
    end

    uart_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_W     (DEPTH_LOG2)
    ) u_mem (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (wr_ptr[DEPTH_LOG2-1:0]),
        .wdata (bus.data_i),
        .raddr (rd_ptr[DEPTH_LOG2-1:0]),
        .rdata (head)
    );

    // Mask the unreset array so data_o reads zero while empty.
    assign bus.data_o      = empty_w ? '0 : head;
    assign bus.empty       = empty_w;
    assign bus.full        = full_w;
    assign bus.almost_full = (level_w >= AF_LEVEL);
    assign bus.level       = level_w;
    assign bus.overflow    = overflow_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with hand-computed expectations.
module tb_uart_rx_fifo;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nvec = 0;
    int   nerr = 0;

    uart_rx_fifo_if bus ();

    uart_rx_fifo dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One receiver frame: strobe low for a cycle, then high with data; write lands at the next edge.
    task automatic frame(input logic [7:0] d);
        bus.ena_rxd = 1'b0;
        step();
        bus.ena_rxd = 1'b1;
        bus.data_i  = d;
        step();
    endtask

    task automatic pop_one();
        bus.rd_en = 1'b1;
        step();
        bus.rd_en = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        nvec++; if (bus.empty !== 1'b1) begin nerr++; $display("FAIL rst_empty got=%b exp=1", bus.empty); end
        nvec++; if (bus.full !== 1'b0) begin nerr++; $display("FAIL rst_full got=%b exp=0", bus.full); end
        nvec++; if (bus.almost_full !== 1'b0) begin nerr++; $display("FAIL rst_af got=%b exp=0", bus.almost_full); end
        nvec++; if (bus.level !== 5'd0) begin nerr++; $display("FAIL rst_level got=%0d exp=0", bus.level); end
        nvec++; if (bus.overflow !== 1'b0) begin nerr++; $display("FAIL rst_ovf got=%b exp=0", bus.overflow); end
        nvec++; if (bus.data_o !== 8'h00) begin nerr++; $display("FAIL rst_data got=%h exp=00", bus.data_o); end
        step();
        rst = 1'b0;
        repeat (50) step();
        nvec++; if (bus.empty !== 1'b1) begin nerr++; $display("FAIL idle_empty got=%b exp=1", bus.empty); end
        nvec++; if (bus.level !== 5'd0) begin nerr++; $display("FAIL idle_level got=%0d exp=0", bus.level); end
    endtask

    task automatic test_single();
        frame(8'hA5);
        nvec++; if (bus.empty !== 1'b0) begin nerr++; $display("FAIL single_empty got=%b exp=0", bus.empty); end
        nvec++; if (bus.level !== 5'd1) begin nerr++; $display("FAIL single_level got=%0d exp=1", bus.level); end
        nvec++; if (bus.data_o !== 8'hA5) begin nerr++; $display("FAIL single_data got=%h exp=a5", bus.data_o); end
        pop_one();
        nvec++; if (bus.empty !== 1'b1) begin nerr++; $display("FAIL single_pop_empty got=%b exp=1", bus.empty); end
        nvec++; if (bus.level !== 5'd0) begin nerr++; $display("FAIL single_pop_level got=%0d exp=0", bus.level); end
        pop_one();
        nvec++; if (bus.level !== 5'd0) begin nerr++; $display("FAIL empty_pop_level got=%0d exp=0", bus.level); end
    endtask

    task automatic test_fill_overflow();
        logic exp_af, exp_full;
        for (int i = 0; i < 16; i++) begin
            frame(8'(i));
            exp_af   = (i + 1 >= 12);
            exp_full = (i == 15);
            nvec++; if (bus.level !== 5'(i + 1)) begin nerr++; $display("FAIL fill_level[%0d] got=%0d exp=%0d", i, bus.level, i + 1); end
            nvec++; if (bus.almost_full !== exp_af) begin nerr++; $display("FAIL fill_af[%0d] got=%b exp=%b", i, bus.almost_full, exp_af); end
            nvec++; if (bus.full !== exp_full) begin nerr++; $display("FAIL fill_full[%0d] got=%b exp=%b", i, bus.full, exp_full); end
        end
        frame(8'h55);
        nvec++; if (bus.overflow !== 1'b1) begin nerr++; $display("FAIL ovf_set got=%b exp=1", bus.overflow); end
        nvec++; if (bus.level !== 5'd16) begin nerr++; $display("FAIL ovf_level got=%0d exp=16", bus.level); end
        for (int i = 0; i < 16; i++) begin
            nvec++; if (bus.data_o !== 8'(i)) begin nerr++; $display("FAIL drain[%0d] got=%h exp=%h", i, bus.data_o, 8'(i)); end
            pop_one();
        end
        nvec++; if (bus.empty !== 1'b1) begin nerr++; $display("FAIL drain_empty got=%b exp=1", bus.empty); end
    endtask

    task automatic test_full_simul();
        bus.clr_ovf = 1'b1;
        step();
        bus.clr_ovf = 1'b0;
        for (int i = 0; i < 16; i++) frame(8'(8'h10 + i));
        nvec++; if (bus.full !== 1'b1) begin nerr++; $display("FAIL simul_pre_full got=%b exp=1", bus.full); end
        bus.ena_rxd = 1'b0;
        step();
        bus.ena_rxd = 1'b1;
        bus.data_i  = 8'h77;
        bus.rd_en   = 1'b1;
        step();
        bus.rd_en   = 1'b0;
        nvec++; if (bus.level !== 5'd16) begin nerr++; $display("FAIL simul_level got=%0d exp=16", bus.level); end
        nvec++; if (bus.overflow !== 1'b0) begin nerr++; $display("FAIL simul_ovf got=%b exp=0", bus.overflow); end
        for (int i = 1; i < 16; i++) begin
            nvec++; if (bus.data_o !== 8'(8'h10 + i)) begin nerr++; $display("FAIL simul_drain[%0d] got=%h exp=%h", i, bus.data_o, 8'(8'h10 + i)); end
            pop_one();
        end
        nvec++; if (bus.data_o !== 8'h77) begin nerr++; $display("FAIL simul_last got=%h exp=77", bus.data_o); end
        pop_one();
        nvec++; if (bus.empty !== 1'b1) begin nerr++; $display("FAIL simul_empty got=%b exp=1", bus.empty); end
    endtask

    task automatic test_ovf_clear();
        for (int i = 0; i < 17; i++) frame(8'(8'h20 + i));
        nvec++; if (bus.overflow !== 1'b1) begin nerr++; $display("FAIL clr_pre got=%b exp=1", bus.overflow); end
        bus.clr_ovf = 1'b1;
        step();
        bus.clr_ovf = 1'b0;
        nvec++; if (bus.overflow !== 1'b0) begin nerr++; $display("FAIL clr_alone got=%b exp=0", bus.overflow); end
        bus.ena_rxd = 1'b0;
        step();
        bus.ena_rxd = 1'b1;
        bus.data_i  = 8'h99;
        bus.clr_ovf = 1'b1;
        step();
        bus.clr_ovf = 1'b0;
        nvec++; if (bus.overflow !== 1'b1) begin nerr++; $display("FAIL clr_race got=%b exp=1", bus.overflow); end
        nvec++; if (bus.level !== 5'd16) begin nerr++; $display("FAIL clr_race_level got=%0d exp=16", bus.level); end
        for (int i = 0; i < 16; i++) begin
            nvec++; if (bus.data_o !== 8'(8'h20 + i)) begin nerr++; $display("FAIL clr_drain[%0d] got=%h exp=%h", i, bus.data_o, 8'(8'h20 + i)); end
            pop_one();
        end
        bus.clr_ovf = 1'b1;
        step();
        bus.clr_ovf = 1'b0;
    endtask

    task automatic test_wrap_reset();
        logic [7:0] exp_q[$];
        for (int i = 0; i < 40; i++) begin
            frame(8'(i));
            exp_q.push_back(8'(i));
            nvec++; if (bus.level !== 5'(exp_q.size())) begin nerr++; $display("FAIL wrap_level[%0d] got=%0d exp=%0d", i, bus.level, exp_q.size()); end
            if (exp_q.size() >= 4) begin
                nvec++; if (bus.data_o !== exp_q[0]) begin nerr++; $display("FAIL wrap_data[%0d] got=%h exp=%h", i, bus.data_o, exp_q[0]); end
                void'(exp_q.pop_front());
                pop_one();
            end
        end
        while (exp_q.size() > 0) begin
            nvec++; if (bus.data_o !== exp_q[0]) begin nerr++; $display("FAIL wrap_tail got=%h exp=%h", bus.data_o, exp_q[0]); end
            void'(exp_q.pop_front());
            pop_one();
        end
        frame(8'hA0);
        frame(8'hA1);
        frame(8'hA2);
        nvec++; if (bus.level !== 5'd3) begin nerr++; $display("FAIL prerst_level got=%0d exp=3", bus.level); end
        #1;
        rst = 1'b1;
        #1;
        nvec++; if (bus.empty !== 1'b1) begin nerr++; $display("FAIL midrst_empty got=%b exp=1", bus.empty); end
        nvec++; if (bus.level !== 5'd0) begin nerr++; $display("FAIL midrst_level got=%0d exp=0", bus.level); end
        step();
        rst = 1'b0;
        step();
        nvec++; if (bus.level !== 5'd0) begin nerr++; $display("FAIL postrst_level got=%0d exp=0", bus.level); end
        frame(8'hC3);
        frame(8'h3C);
        nvec++; if (bus.data_o !== 8'hC3) begin nerr++; $display("FAIL postrst_d0 got=%h exp=c3", bus.data_o); end
        pop_one();
        nvec++; if (bus.data_o !== 8'h3C) begin nerr++; $display("FAIL postrst_d1 got=%h exp=3c", bus.data_o); end
        pop_one();
        nvec++; if (bus.empty !== 1'b1) begin nerr++; $display("FAIL postrst_empty got=%b exp=1", bus.empty); end
    endtask

    initial begin
        bus.ena_rxd = 1'b1;
        bus.data_i  = 8'h00;
        bus.rd_en   = 1'b0;
        bus.clr_ovf = 1'b0;
        test_reset();
        test_single();
        test_fill_overflow();
        test_full_simul();
        test_ovf_clear();
        test_wrap_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
